// File: rtl/seq3_pkg.sv
// Shared definitions for the 3-bit sequence monitor.
//   - FSM state encoding
//   - counter code -> ordinal table
//   - sequence length
package seq3_pkg;

   localparam int SEQ_LEN = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HUNT   = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      HUNT   = ST_HUNT,
      LOCKED = ST_LOCKED
   } state_t;

   // Counter cycle 000>111>001>110>010>101>011>100 gives ordinals 0..7.
   // Indexed by code {C,B,A}; entry 7 first.
   localparam logic [SEQ_LEN-1:0][2:0] ORD_TBL = {
      3'd1,   // 111
      3'd3,   // 110
      3'd5,   // 101
      3'd7,   // 100
      3'd6,   // 011
      3'd4,   // 010
      3'd2,   // 001
      3'd0    // 000
   };

endpackage

// File: rtl/seq3_decode.sv
// Combinational decode of a counter code to its position in the cycle.
//   code : 3-bit counter state {C,B,A}
//   ord  : ordinal 0..7 of that code in the counter cycle
module seq3_decode
   import seq3_pkg::*;
(
   input  logic [2:0] code,
   output logic [2:0] ord
);

   assign ord = ORD_TBL[code];

endmodule

// File: rtl/seq3_monitor.sv
// Downstream checker for the 3-bit sequence counter.
// Samples {C,B,A} on each enabled clock, decodes it to an ordinal, locks
// after LOCK_N good steps and, while locked, flags/counts bad steps and
// counts completed laps.
//   CLK, RST_N : clock, async active-low reset
//   C, B, A    : counter bits (C = MSB)
//   EN         : sample strobe; 0 freezes state and suppresses pulses
//   CLR_ERR    : synchronous clear of ERR_CNT (works regardless of EN)
//   IDX        : ordinal of last sampled code
//   LOCK       : high while locked
//   ERR, WRAP  : single-cycle pulses (bad step / good step into 0, locked)
//   ERR_CNT    : saturating error count
//   LAP_CNT    : wrapping lap count
module seq3_monitor
   import seq3_pkg::*;
#(
   parameter int LOCK_N   = 3,
   parameter int UNLOCK_N = 2,
   parameter int ERR_W    = 8,
   parameter int LAP_W    = 4
)(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             C,
   input  logic             B,
   input  logic             A,
   input  logic             EN,
   input  logic             CLR_ERR,
   output logic [2:0]       IDX,
   output logic             LOCK,
   output logic             ERR,
   output logic             WRAP,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic [LAP_W-1:0] LAP_CNT
);

   state_t           state, state_n;
   logic [3:0]       good_run, good_run_n;
   logic [3:0]       bad_run, bad_run_n;
   logic [3:0]       good_inc, bad_inc;
   logic [2:0]       ord, idx_n;
   logic             good;
   logic             lock_n, err_n, wrap_n;
   logic [ERR_W-1:0] err_cnt_n;
   logic [LAP_W-1:0] lap_cnt_n;

   seq3_decode u_dec (
      .code ({C, B, A}),
      .ord  (ord)
   );

   // IDX doubles as the previous-sample register; 3-bit add wraps 7->0.
   assign good     = (ord == IDX + 3'd1);
   assign good_inc = (good_run == 4'hF) ? good_run : good_run + 4'd1;
   assign bad_inc  = (bad_run  == 4'hF) ? bad_run  : bad_run  + 4'd1;

   always_comb begin
      state_n    = state;
      good_run_n = good_run;
      bad_run_n  = bad_run;
      idx_n      = IDX;
      err_n      = 1'b0;
      wrap_n     = 1'b0;
      err_cnt_n  = ERR_CNT;
      lap_cnt_n  = LAP_CNT;
      if (EN) begin
         idx_n = ord;
         case (state)
            IDLE: begin
               state_n    = HUNT;
               good_run_n = 4'd0;
            end
            HUNT: begin
               if (good) begin
                  good_run_n = good_inc;
                  if (good_inc >= 4'(LOCK_N)) begin
                     state_n   = LOCKED;
                     bad_run_n = 4'd0;
                     wrap_n    = (ord == 3'd0);
                  end
               end else begin
                  good_run_n = 4'd0;
               end
            end
            LOCKED: begin
               if (good) begin
                  bad_run_n = 4'd0;
                  wrap_n    = (ord == 3'd0);
               end else begin
                  err_n     = 1'b1;
                  bad_run_n = bad_inc;
                  if (ERR_CNT != '1)
                     err_cnt_n = ERR_CNT + ERR_W'(1);
                  if (bad_inc >= 4'(UNLOCK_N)) begin
                     state_n    = HUNT;
                     good_run_n = 4'd0;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
      if (wrap_n)
         lap_cnt_n = LAP_CNT + LAP_W'(1);
      // Clear beats a same-cycle increment.
      if (CLR_ERR)
         err_cnt_n = '0;
      lock_n = (state_n == LOCKED);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         good_run <= '0;
         bad_run  <= '0;
         IDX      <= '0;
         LOCK     <= 1'b0;
         ERR      <= 1'b0;
         WRAP     <= 1'b0;
         ERR_CNT  <= '0;
         LAP_CNT  <= '0;
      end else begin
         good_run <= good_run_n;
         bad_run  <= bad_run_n;
         IDX      <= idx_n;
         LOCK     <= lock_n;
         ERR      <= err_n;
         WRAP     <= wrap_n;
         ERR_CNT  <= err_cnt_n;
         LAP_CNT  <= lap_cnt_n;
      end
   end

endmodule

// File: tb/tb_seq3_monitor.sv
// Directed bench for seq3_monitor: lock acquisition, laps, skip/stall
// errors, error-count saturation and clear, enable gaps, async reset.
module tb_seq3_monitor;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       C = 1'b0, B = 1'b0, A = 1'b0;
   logic       EN = 1'b0;
   logic       CLR_ERR = 1'b0;
   logic [2:0] IDX;
   logic       LOCK, ERR, WRAP;
   logic [7:0] ERR_CNT;
   logic [3:0] LAP_CNT;

   int checks = 0;
   int failures = 0;

   seq3_monitor dut (
      .CLK(CLK), .RST_N(RST_N), .C(C), .B(B), .A(A), .EN(EN),
      .CLR_ERR(CLR_ERR), .IDX(IDX), .LOCK(LOCK), .ERR(ERR), .WRAP(WRAP),
      .ERR_CNT(ERR_CNT), .LAP_CNT(LAP_CNT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [2:0] cd(input int o);
      case (o % 8)
         0: cd = 3'b000;
         1: cd = 3'b111;
         2: cd = 3'b001;
         3: cd = 3'b110;
         4: cd = 3'b010;
         5: cd = 3'b101;
         6: cd = 3'b011;
         default: cd = 3'b100;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input int idx, input int lock,
                       input int err, input int wrap);
      chk({tag, ".IDX"},  {29'd0, IDX}, idx);
      chk({tag, ".LOCK"}, {31'd0, LOCK}, lock);
      chk({tag, ".ERR"},  {31'd0, ERR}, err);
      chk({tag, ".WRAP"}, {31'd0, WRAP}, wrap);
   endtask

   // Drive one sample between edges, then look #1 after the rising edge.
   task automatic step(input logic [2:0] code, input logic en, input logic clr);
      @(negedge CLK);
      {C, B, A} = code;
      EN = en;
      CLR_ERR = clr;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int cur;
      // ---- reset ----
      #2;
      outs("rst", 0, 0, 0, 0);
      chk("rst.ERR_CNT", {24'd0, ERR_CNT}, 0);
      chk("rst.LAP_CNT", {28'd0, LAP_CNT}, 0);
      @(negedge CLK);
      RST_N = 1'b1;

      // ---- 1: acquire lock from 000, LOCK on the 4th sample edge ----
      step(cd(0), 1, 0); outs("t1.s0", 0, 0, 0, 0);
      step(cd(1), 1, 0); outs("t1.s1", 1, 0, 0, 0);
      step(cd(2), 1, 0); outs("t1.s2", 2, 0, 0, 0);
      step(cd(3), 1, 0); outs("t1.s3", 3, 1, 0, 0);

      // ---- 2: two laps: ordinals 4..7, 0..7, 0 ----
      for (int i = 4; i <= 16; i++) begin
         step(cd(i), 1, 0);
         outs($sformatf("t2.o%0d", i), i % 8, 1, 0, (i % 8 == 0) ? 1 : 0);
      end
      chk("t2.LAP_CNT", {28'd0, LAP_CNT}, 2);
      chk("t2.ERR_CNT", {24'd0, ERR_CNT}, 0);

      // ---- 3: skip 001 -> 010, then good step clears bad run ----
      step(cd(1), 1, 0); outs("t3.o1", 1, 1, 0, 0);
      step(cd(2), 1, 0); outs("t3.o2", 2, 1, 0, 0);
      step(cd(4), 1, 0); outs("t3.skip", 4, 1, 1, 0);
      chk("t3.ERR_CNT", {24'd0, ERR_CNT}, 1);
      step(cd(5), 1, 0); outs("t3.good", 5, 1, 0, 0);
      // a lone bad step now must not unlock if the good step reset bad_run
      step(cd(5), 1, 0); outs("t3.stall", 5, 1, 1, 0);
      chk("t3.ERR_CNT2", {24'd0, ERR_CNT}, 2);
      step(cd(6), 1, 0); outs("t3.o6", 6, 1, 0, 0);

      // ---- 4: two stalls drop lock, relock after 3 good steps ----
      step(cd(6), 1, 0); outs("t4.st1", 6, 1, 1, 0);
      chk("t4.ERR_CNT1", {24'd0, ERR_CNT}, 3);
      step(cd(6), 1, 0); outs("t4.st2", 6, 0, 1, 0);
      chk("t4.ERR_CNT2", {24'd0, ERR_CNT}, 4);
      step(cd(7), 1, 0); outs("t4.h7", 7, 0, 0, 0);
      step(cd(0), 1, 0); outs("t4.h0", 0, 0, 0, 0);   // 7->0 while hunting: no WRAP
      step(cd(1), 1, 0); outs("t4.h1", 1, 1, 0, 0);
      chk("t4.LAP_CNT", {28'd0, LAP_CNT}, 2);

      // ---- 5: 300 more errors via stall/stall/relock cycles ----
      cur = 1;
      for (int k = 1; k <= 150; k++) begin
         step(cd(cur), 1, 0);
         step(cd(cur), 1, 0);
         for (int j = 0; j < 3; j++) begin
            cur = (cur + 1) % 8;
            step(cd(cur), 1, 0);
         end
         chk($sformatf("t5.ERR_CNT.k%0d", k), {24'd0, ERR_CNT},
             (4 + 2 * k > 255) ? 255 : 4 + 2 * k);
      end
      chk("t5.LOCK", {31'd0, LOCK}, 1);
      chk("t5.IDX", {29'd0, IDX}, 3);
      // 19 of the 150 lock-entry steps land on ordinal 0: 2 + 19 = 21 -> 5 mod 16
      chk("t5.LAP_CNT", {28'd0, LAP_CNT}, 5);
      // clear on an error cycle: ERR still pulses, count goes to 0
      step(cd(3), 1, 1); outs("t5.clr", 3, 1, 1, 0);
      chk("t5.clr.ERR_CNT", {24'd0, ERR_CNT}, 0);
      step(cd(4), 1, 0); outs("t5.o4", 4, 1, 0, 0);
      step(cd(4), 1, 0); outs("t5.st", 4, 1, 1, 0);
      chk("t5.st.ERR_CNT", {24'd0, ERR_CNT}, 1);
      step(cd(1), 0, 1); outs("t5.clr_noen", 4, 1, 0, 0);
      chk("t5.clr_noen.ERR_CNT", {24'd0, ERR_CNT}, 0);
      step(cd(5), 1, 0); outs("t5.o5", 5, 1, 0, 0);

      // ---- 6: enable gap with changing input, then resume ----
      for (int g = 0; g < 5; g++) begin
         step(3'($urandom_range(0, 7)), 0, 0);
         outs($sformatf("t6.gap%0d", g), 5, 1, 0, 0);
      end
      step(cd(6), 1, 0); outs("t6.o6", 6, 1, 0, 0);
      step(cd(7), 1, 0); outs("t6.o7", 7, 1, 0, 0);
      step(cd(0), 1, 0); outs("t6.o0", 0, 1, 0, 1);
      chk("t6.LAP_CNT", {28'd0, LAP_CNT}, 6);
      chk("t6.ERR_CNT", {24'd0, ERR_CNT}, 0);
      // make counters nonzero so the reset check is meaningful
      step(cd(0), 1, 0); outs("t6.st", 0, 1, 1, 0);
      #2;
      RST_N = 1'b0;
      #1;
      outs("t6.rst", 0, 0, 0, 0);
      chk("t6.rst.ERR_CNT", {24'd0, ERR_CNT}, 0);
      chk("t6.rst.LAP_CNT", {28'd0, LAP_CNT}, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      step(cd(5), 0, 0); outs("t6.post", 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
